// File: rtl/din_sync_debounce.sv
// Async input receiver: reset-release bridge, input synchronizer, debounce filter,
// clean edge pulses and a wrapping transition counter.
module din_sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned RST_STAGES      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_i,
    input  logic             clr_i,
    output logic             rst_done_o,
    output logic             q_sync_o,
    output logic             q_stable_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [RST_STAGES-1:0]  rst_pipe;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [DB_W-1:0]        db_cnt;

    logic [DB_W-1:0]        db_cnt_nxt;
    logic                   stable_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic [CNT_W-1:0]       edge_cnt_nxt;

    // Reset bridge: asserts with reset, releases after RST_STAGES clean edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[RST_STAGES-2:0], 1'b1};
        end
    end

    assign rst_done_o = rst_pipe[RST_STAGES-1];
    assign q_sync_o   = sync_pipe[SYNC_STAGES-1];

    // Debounce filter, pulse generation and transition count.
    always_comb begin
        db_cnt_nxt   = db_cnt;
        stable_nxt   = q_stable_o;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;
        edge_cnt_nxt = edge_cnt_o;
        if (q_sync_o == q_stable_o) begin
            db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt_nxt = '0;
            stable_nxt = q_sync_o;
            rise_nxt   = q_sync_o;
            fall_nxt   = !q_sync_o;
        end else begin
            db_cnt_nxt = db_cnt + 1'b1;
        end
        // Clear first so a coincident transition still counts as one.
        if (clr_i) begin
            edge_cnt_nxt = '0;
        end
        if (rise_nxt || fall_nxt) begin
            edge_cnt_nxt = edge_cnt_nxt + 1'b1;
        end
    end

    // Everything downstream of the bridge holds its reset value until release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_pipe  <= '0;
            db_cnt     <= '0;
            q_stable_o <= 1'b0;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            edge_cnt_o <= '0;
        end else if (rst_done_o) begin
            sync_pipe  <= {sync_pipe[SYNC_STAGES-2:0], d_i};
            db_cnt     <= db_cnt_nxt;
            q_stable_o <= stable_nxt;
            rise_o     <= rise_nxt;
            fall_o     <= fall_nxt;
            edge_cnt_o <= edge_cnt_nxt;
        end
    end

endmodule
